sync_fifo_param: RTL

//  Parametrised single-clock FIFO, successor to the fixed 8x16 FIFO. Adds configurable width and depth,

---
 rtl/sync_fifo_pkg.sv | 26 ++
 rtl/sync_fifo_ram.sv | 25 ++
 rtl/sync_fifo_param.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: defaults, status bundle, sizing helpers.
package sync_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_AF    = 12;
  localparam int DEF_AE    = 4;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, contents never reset.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy flags, overflow/underflow pulses and optional FWFT read.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter int               AF_THRESH = DEF_AF,
  parameter int               AE_THRESH = DEF_AE,
  parameter int               FWFT      = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = 8'hFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);
  localparam logic [ADDR_W:0]  PTR_ONE = (ADDR_W+1)'(1);

  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 4");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [ADDR_W:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0] occ;
  logic             wr_accept, rd_accept;
  logic             ovf_q, udf_q, dv_q;
  logic [WIDTH-1:0] dout_q, rdata;
  fifo_status_t     status;

  // The extra pointer bit makes the difference span 0..DEPTH, so the
  // occupancy is a pure function of registered state.
  assign occ = wr_ptr - rd_ptr;

  always_comb begin
    status              = '0;
    status.full         = (occ == DEPTH_C);
    status.empty        = (occ == '0);
    status.almost_full  = (occ >= AF_C);
    status.almost_empty = (occ <= AE_C);
    status.overflow     = ovf_q;
    status.underflow    = udf_q;
  end

  // A pop in the same cycle frees the slot, so a full FIFO still takes a write.
  assign rd_accept = rd_en & ~status.empty;
  assign wr_accept = wr_en & (~status.full | rd_accept);

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_accept),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(din),
    .raddr(rd_ptr[ADDR_W-1:0]),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      dv_q   <= 1'b0;
      dout_q <= RESET_VAL;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_accept) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        dout_q <= rdata;
      end
      ovf_q <= wr_en & ~wr_accept;
      udf_q <= rd_en & status.empty;
      dv_q  <= rd_accept;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // While empty the RAM output is stale; show the last popped word instead.
    assign dout       = status.empty ? dout_q : rdata;
    assign dout_valid = ~status.empty;
  end else begin : g_std
    assign dout       = dout_q;
    assign dout_valid = dv_q;
  end

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;
  assign count        = occ;

endmodule
